// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port data RAM with req/ready handshake,
// pipelined reads (READ_LAT), bounds checking and a post-reset clear sweep.
// Ports: clk, rst_n | req, mw, position, data_in | ready, busy, data_out, valid, err
module data_memory_ctrl #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 2**ADDR_W,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              mw,
    input  logic [ADDR_W-1:0] position,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              err
);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    localparam state_t            S_RST   = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    // one extra bit so DEPTH == 2**ADDR_W is representable
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                inrange;
    logic                rd_acc;
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;

    logic [READ_LAT-1:0] vld_q;
    logic [DATA_W-1:0]   dat_q [READ_LAT];
    logic                err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready   = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                busy  = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end
            end
            S_IDLE: begin
                // ready must stay low while reset is held, even when
                // the reset state is IDLE
                ready = rst_n;
            end
        endcase
    end

    assign accept  = req & ready;
    assign inrange = {1'b0, position} < DEPTH_C;
    assign rd_acc  = accept & ~mw;

    // the sweep owns the single write port while busy
    assign we    = busy | (accept & mw & inrange);
    assign waddr = busy ? ptr_q : position;
    assign wdata = busy ? '0 : data_in;
    assign rdata = inrange ? mem[position] : '0;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= 1'b0;
            for (int k = 0; k < READ_LAT; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            err_q    <= accept & ~inrange;
            if (rd_acc) begin
                dat_q[0] <= rdata;
            end
            // stages only load on valid so data_out holds between reads
            for (int k = 1; k < READ_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    assign valid    = vld_q[READ_LAT-1];
    assign data_out = dat_q[READ_LAT-1];
    assign err      = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench for data_memory_ctrl
// (DEPTH=200, READ_LAT=2, CLEAR_ON_RESET=1).
module tb_data_memory_ctrl;

    localparam int DEP = 200;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       mw = 1'b0;
    logic [7:0] position = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       ready;
    logic       busy;
    logic [7:0] data_out;
    logic       valid;
    logic       err;

    data_memory_ctrl #(
        .DATA_W(8),
        .ADDR_W(8),
        .DEPTH(DEP),
        .READ_LAT(LAT),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .mw(mw),
        .position(position),
        .data_in(data_in),
        .ready(ready),
        .busy(busy),
        .data_out(data_out),
        .valid(valid),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] d;
        int         c;
    } rd_t;

    rd_t rdq[$];
    int  errq[$];
    int  npass = 0;
    int  ntot = 0;

    function automatic void chk(string nm, int act, int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                      nm, act, exp, cyc);
    endfunction

    always @(negedge clk) begin : mon
        rd_t e;
        if (rst_n) begin
            if (valid) begin
                if (rdq.size() == 0) begin
                    chk("unexpected valid", 1, 0);
                end else begin
                    e = rdq.pop_front();
                    chk("read data", int'(data_out), int'(e.d));
                    chk("read latency", cyc, e.c);
                end
            end
            if (err) begin
                if (errq.size() == 0) chk("unexpected err", 1, 0);
                else chk("err cycle", cyc, errq.pop_front());
            end
        end
    end

    // called at a negedge; the accept edge is the next posedge (cyc+1)
    task automatic op(input bit w, input logic [7:0] p, input logic [7:0] d,
                      input bit exp_rd, input logic [7:0] exp,
                      input bit exp_err);
        rd_t e;
        chk("ready at issue", int'(ready), 1);
        req      = 1'b1;
        mw       = w;
        position = p;
        data_in  = d;
        if (!w && exp_rd) begin
            e.d = exp;
            e.c = cyc + LAT;
            rdq.push_back(e);
        end
        if (exp_err) errq.push_back(cyc + 1);
        @(negedge clk);
        req = 1'b0;
        mw  = 1'b0;
    endtask

    task automatic drain();
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic measure_clear(string nm);
        int n;
        n = 0;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        mw  = 1'b0;
        chk(nm, n, DEP);
        chk("busy after clear", int'(busy), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset data_out", int'(data_out), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset err", int'(err), 0);
        chk("reset ready", int'(ready), 0);
        chk("reset busy", int'(busy), 1);

        // out-of-range write held during the sweep must be ignored
        req      = 1'b1;
        mw       = 1'b1;
        position = 8'hFF;
        data_in  = 8'h33;
        rst_n    = 1'b1;
        measure_clear("clear length");

        for (int i = 0; i < DEP; i++) begin
            op(1'b0, 8'(i), 8'h00, 1'b1, 8'h00, 1'b0);
        end
        drain();

        op(1'b1, 8'h10, 8'h09, 1'b0, 8'h00, 1'b0);
        op(1'b0, 8'h10, 8'h00, 1'b1, 8'h09, 1'b0);
        drain();

        op(1'b1, 8'h11, 8'h0A, 1'b0, 8'h00, 1'b0);
        op(1'b1, 8'h12, 8'h0B, 1'b0, 8'h00, 1'b0);
        op(1'b0, 8'h10, 8'h00, 1'b1, 8'h09, 1'b0);
        op(1'b0, 8'h11, 8'h00, 1'b1, 8'h0A, 1'b0);
        op(1'b0, 8'h12, 8'h00, 1'b1, 8'h0B, 1'b0);
        drain();
        chk("valid idle", int'(valid), 0);
        chk("data_out hold", int'(data_out), 8'h0B);

        op(1'b1, 8'hFF, 8'h09, 1'b0, 8'h00, 1'b1);
        op(1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        op(1'b1, 8'hC7, 8'h5A, 1'b0, 8'h00, 1'b0);
        op(1'b1, 8'hC8, 8'hA5, 1'b0, 8'h00, 1'b1);
        op(1'b0, 8'hC7, 8'h00, 1'b1, 8'h5A, 1'b0);
        op(1'b0, 8'hC8, 8'h00, 1'b1, 8'h00, 1'b1);
        drain();
        chk("err idle", int'(err), 0);

        mw       = 1'b1;
        position = 8'h10;
        data_in  = 8'h55;
        repeat (3) @(negedge clk);
        mw = 1'b0;
        op(1'b0, 8'h10, 8'h00, 1'b1, 8'h09, 1'b0);
        drain();

        // in-flight read discarded by reset
        op(1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("busy on reset", int'(busy), 1);
        chk("ready on reset", int'(ready), 0);
        chk("valid on reset", int'(valid), 0);
        @(negedge clk);
        chk("data_out on reset", int'(data_out), 0);
        // read held during the sweep must be ignored
        req      = 1'b1;
        mw       = 1'b0;
        position = 8'h10;
        rst_n    = 1'b1;
        measure_clear("clear length after reset");
        op(1'b0, 8'h10, 8'h00, 1'b1, 8'h00, 1'b0);
        op(1'b0, 8'h12, 8'h00, 1'b1, 8'h00, 1'b0);
        drain();

        chk("reads outstanding", rdq.size(), 0);
        chk("errs outstanding", errq.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
